// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU op codes and the decoded control bundle.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } aluOp_e;
  typedef struct packed {
    aluOp_e     aluOp;
    logic       aluSrc;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       zeroExt;
    logic       readsRt;
    logic [4:0] dest;
  } ctrl_t;
endpackage

// File: rtl/mips_decode_stage_control.sv
// mips_control_decode: combinational opcode/funct decode into the control bundle.
module mips_control_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);
  logic [5:0] op, funct;
  logic [4:0] rt, rd;
  logic       wr;
  logic       unusedShamt;
  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign unusedShamt = ^instr[10:6] ^ ^instr[25:21];
  always_comb begin
    ctrl = '0;
    wr   = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.readsRt = 1'b1;
        wr           = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        ctrl.dest    = wr ? rd : 5'd0;
        ctrl.aluOp   = funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND :
                       funct == FN_OR ? ALU_OR : funct == FN_SLT ? ALU_SLT : ALU_ADD;
      end
      OP_ADDI: begin
        wr          = 1'b1;
        ctrl.aluSrc = 1'b1;
        ctrl.dest   = rt;
      end
      OP_ANDI, OP_ORI: begin
        wr           = 1'b1;
        ctrl.aluSrc  = 1'b1;
        ctrl.zeroExt = 1'b1;
        ctrl.dest    = rt;
        ctrl.aluOp   = op == OP_ANDI ? ALU_AND : ALU_OR;
      end
      OP_LW: begin
        wr           = 1'b1;
        ctrl.aluSrc  = 1'b1;
        ctrl.memRead = 1'b1;
        ctrl.dest    = rt;
      end
      OP_SW: begin
        ctrl.aluSrc   = 1'b1;
        ctrl.memWrite = 1'b1;
        ctrl.readsRt  = 1'b1;
      end
      OP_BEQ: begin
        ctrl.aluOp   = ALU_SUB;
        ctrl.branch  = 1'b1;
        ctrl.readsRt = 1'b1;
      end
      default: ;
    endcase
    ctrl.regWrite = wr && ctrl.dest != 5'd0;
  end
endmodule

// File: rtl/mips_decode_stage.sv
// mips_decode_stage: MIPS ID stage with operand capture, load-use bubbles and ID/EX register.
// Define MIPS_WB_BYPASS_EN to forward the write-back port into the captured operands.
module mips_decode_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  input  logic        flush,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch
);
  ctrl_t       ctrl;
  logic [4:0]  rsAddr, rtAddr;
  logic [31:0] rsVal, rtVal, immExt;
  logic        hazard;
  mips_control_decode uDecode (.instr(if_instr), .ctrl(ctrl));
  assign rsAddr    = if_instr[25:21];
  assign rtAddr    = if_instr[20:16];
  assign rf_raddr1 = rsAddr;
  assign rf_raddr2 = rtAddr;
  assign immExt    = ctrl.zeroExt ? {16'h0, if_instr[15:0]} : {{16{if_instr[15]}}, if_instr[15:0]};
`ifdef MIPS_WB_BYPASS_EN
  // Covers the register-file write that lands on the same edge as the ID/EX capture.
  assign rsVal = rsAddr == 5'd0 ? 32'h0 : (wb_we && wb_waddr == rsAddr) ? wb_wdata : rf_rdata1;
  assign rtVal = rtAddr == 5'd0 ? 32'h0 : (wb_we && wb_waddr == rtAddr) ? wb_wdata : rf_rdata2;
`else
  logic unusedWb;
  assign unusedWb = wb_we ^ ^wb_waddr ^ ^wb_wdata;
  assign rsVal    = rsAddr == 5'd0 ? 32'h0 : rf_rdata1;
  assign rtVal    = rtAddr == 5'd0 ? 32'h0 : rf_rdata2;
`endif
  assign hazard   = ex_valid && ex_mem_read && ex_rd != 5'd0 &&
                    (ex_rd == rsAddr || (ctrl.readsRt && ex_rd == rtAddr));
  assign id_ready = flush || ((!ex_valid || ex_ready) && !hazard);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs_val    <= '0;
      ex_rt_val    <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
    end else if (flush) ex_valid <= 1'b0;
    else if (if_valid && id_ready) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_rs_val    <= rsVal;
      ex_rt_val    <= rtVal;
      ex_imm       <= immExt;
      ex_rd        <= ctrl.dest;
      ex_alu_op    <= ctrl.aluOp;
      ex_alu_src   <= ctrl.aluSrc;
      ex_reg_write <= ctrl.regWrite;
      ex_mem_read  <= ctrl.memRead;
      ex_mem_write <= ctrl.memWrite;
      ex_branch    <= ctrl.branch;
    end else if (ex_ready) ex_valid <= 1'b0;
endmodule

// File: tb/tb_mips_decode_stage.sv
// tb_mips_decode_stage: directed checks of decode, bubbles, stall/flush, bypass and async reset.
module tb_mips_decode_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b1;
  logic [31:0] if_instr = '0, if_pc = '0, rf_rdata1 = '0, rf_rdata2 = '0, wb_wdata = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic        id_ready, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [4:0]  rf_raddr1, rf_raddr2, ex_rd;
  logic [31:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm;
  logic [3:0]  ex_alu_op;
  int          checks = 0, passed = 0;
  always #5 clk = ~clk;
  mips_decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask
  initial begin
    #3;
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_ready", id_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    issue(32'h20080005, 32'h100);
    rf_rdata1 = 32'h55555555;
    #1;
    chk("raddr1", rf_raddr1, 0);
    chk("raddr2", rf_raddr2, 8);
    tick();
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 5);
    chk("addi_rd", ex_rd, 8);
    chk("addi_src", ex_alu_src, 1);
    chk("addi_wr", ex_reg_write, 1);
    chk("addi_op", ex_alu_op, 0);
    chk("addi_pc", ex_pc, 32'h100);
    chk("addi_zero_rs", ex_rs_val, 0);
    issue(32'h300BFFFF, 32'h104);
    tick();
    chk("andi_imm", ex_imm, 32'h0000FFFF);
    chk("andi_rd", ex_rd, 11);
    chk("andi_op", ex_alu_op, 2);
    issue(32'h200BFFFF, 32'h108);
    tick();
    chk("addi_neg_imm", ex_imm, 32'hFFFFFFFF);
    issue(32'h8C090000, 32'h10C);
    tick();
    chk("lw_mr", ex_mem_read, 1);
    chk("lw_rd", ex_rd, 9);
    issue(32'h01295020, 32'h110);
    #1;
    chk("lu_stall", id_ready, 0);
    tick();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_release", id_ready, 1);
    tick();
    chk("add_valid", ex_valid, 1);
    chk("add_pc", ex_pc, 32'h110);
    chk("add_rd", ex_rd, 10);
    chk("add_mr", ex_mem_read, 0);
    issue(32'h01205020, 32'h114);
    rf_rdata1 = 32'h1111;
    wb_we = 1'b1;
    wb_waddr = 5'd9;
    wb_wdata = 32'hDEAD;
    tick();
`ifdef MIPS_WB_BYPASS_EN
    chk("bypass_rs", ex_rs_val, 32'hDEAD);
`else
    chk("nobypass_rs", ex_rs_val, 32'h1111);
`endif
    issue(32'h00095020, 32'h118);
    wb_waddr = 5'd0;
    rf_rdata1 = 32'h1234;
    rf_rdata2 = 32'h77;
    tick();
    chk("wb0_rs", ex_rs_val, 0);
    chk("wb0_rt", ex_rt_val, 32'h77);
    wb_we = 1'b0;
    issue(32'hAD490004, 32'h11C);
    tick();
    chk("sw_mw", ex_mem_write, 1);
    chk("sw_rd", ex_rd, 0);
    chk("sw_wr", ex_reg_write, 0);
    chk("sw_imm", ex_imm, 4);
    ex_ready = 1'b0;
    issue(32'hFC000000, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", id_ready, 0);
      tick();
      chk("stall_valid", ex_valid, 1);
      chk("stall_pc", ex_pc, 32'h11C);
      chk("stall_mw", ex_mem_write, 1);
      chk("stall_imm", ex_imm, 4);
      chk("stall_rt", ex_rt_val, 32'h77);
    end
    flush = 1'b1;
    #1;
    chk("flush_ready", id_ready, 1);
    tick();
    chk("flush_valid", ex_valid, 0);
    flush = 1'b0;
    ex_ready = 1'b1;
    issue(32'hFC000000, 32'h300);
    tick();
    chk("nop_valid", ex_valid, 1);
    chk("nop_rd", ex_rd, 0);
    chk("nop_wr", ex_reg_write, 0);
    chk("nop_src", ex_alu_src, 0);
    chk("nop_pc", ex_pc, 32'h300);
    issue(32'h10490003, 32'h304);
    tick();
    chk("beq_br", ex_branch, 1);
    chk("beq_op", ex_alu_op, 1);
    chk("beq_rd", ex_rd, 0);
    issue(32'h01295020, 32'h308);
    flush = 1'b1;
    tick();
    chk("flushin_valid", ex_valid, 0);
    flush = 1'b0;
    issue(32'h20080005, 32'h400);
    tick();
    chk("pre_rst_valid", ex_valid, 1);
    if_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_pc", ex_pc, 0);
    chk("arst_imm", ex_imm, 0);
    chk("arst_rd", ex_rd, 0);
    chk("arst_wr", ex_reg_write, 0);
    chk("arst_src", ex_alu_src, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
